// File: rtl/pc_mux_pkg.sv
// Shared definitions for the fetch-path PC select logic.
package pc_mux_pkg;

   localparam int PC_SEL_WIDTH = 2;

   typedef enum logic [PC_SEL_WIDTH-1:0] {
      PC_SEL_NONE = 2'd0,
      PC_SEL_ADD4 = 2'd1,
      PC_SEL_JAL  = 2'd2,
      PC_SEL_JALR = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Parallel next-PC candidate adders: sequential, PC-relative and register-based targets.
module pc_target_calc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] pc_plus_imm,
   output logic [XLEN-1:0] jalr_target
);

   logic [XLEN-1:0] rs1_plus_imm_s;

   // All sums wrap modulo 2^XLEN; JALR drops bit 0 of its sum.
   assign pc_plus4       = pc + {{(XLEN-3){1'b0}}, 3'd4};
   assign pc_plus_imm    = pc + imm;
   assign rs1_plus_imm_s = rs1 + imm;
   assign jalr_target    = rs1_plus_imm_s & {{(XLEN-1){1'b1}}, 1'b0};

endmodule

// File: rtl/pc_next_sel.sv
// Fetch PC register with next-PC selection; stall has priority over every select code.
module pc_next_sel
   import pc_mux_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PC_SEL_WIDTH-1:0] pc_sel,
   input  logic                    taken,
   input  logic                    stall,
   input  logic [XLEN-1:0]         rs1,
   input  logic [XLEN-1:0]         imm,
   output logic [XLEN-1:0]         pc,
   output logic [XLEN-1:0]         next_pc,
   output logic                    redirect,
   output logic                    misaligned
);

   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] next_pc_s;
   logic            redirect_s;
   logic [XLEN-1:0] pc_plus4_s;
   logic [XLEN-1:0] pc_plus_imm_s;
   logic [XLEN-1:0] jalr_target_s;
   pc_sel_t         sel_s;

   assign sel_s = pc_sel_t'(pc_sel);

   pc_target_calc #(.XLEN(XLEN)) u_target_calc (
      .pc          (pc_r),
      .rs1         (rs1),
      .imm         (imm),
      .pc_plus4    (pc_plus4_s),
      .pc_plus_imm (pc_plus_imm_s),
      .jalr_target (jalr_target_s)
   );

   // Next-PC mux and redirect flag, stall first.
   always_comb begin
      next_pc_s  = pc_r;
      redirect_s = 1'b0;
      if (stall) begin
         next_pc_s  = pc_r;
         redirect_s = 1'b0;
      end else begin
         case (sel_s)
            PC_SEL_NONE: begin
               next_pc_s  = pc_r;
               redirect_s = 1'b0;
            end
            PC_SEL_ADD4: begin
               next_pc_s  = pc_plus4_s;
               redirect_s = 1'b0;
            end
            PC_SEL_JAL: begin
               if (taken) begin
                  next_pc_s  = pc_plus_imm_s;
                  redirect_s = 1'b1;
               end else begin
                  next_pc_s  = pc_plus4_s;
                  redirect_s = 1'b0;
               end
            end
            PC_SEL_JALR: begin
               next_pc_s  = jalr_target_s;
               redirect_s = 1'b1;
            end
            default: begin
               next_pc_s  = pc_r;
               redirect_s = 1'b0;
            end
         endcase
      end
   end

   // Architectural PC register; a misaligned target is still loaded, trapping happens downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   assign pc         = pc_r;
   assign next_pc    = next_pc_s;
   assign redirect   = redirect_s;
   assign misaligned = redirect_s & (next_pc_s[1] | next_pc_s[0]);

endmodule

// File: tb/tb_pc_next_sel.sv
// Table-driven bench for pc_next_sel plus hand-written reset sequences.
module tb_pc_next_sel;

   localparam logic [1:0] S_NONE = 2'd0;
   localparam logic [1:0] S_ADD4 = 2'd1;
   localparam logic [1:0] S_JAL  = 2'd2;
   localparam logic [1:0] S_JALR = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  pc_sel;
   logic        taken;
   logic        stall;
   logic [31:0] rs1;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect;
   logic        misaligned;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        stall;
      logic [1:0]  sel;
      logic        taken;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
      logic        exp_red;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[$];

   pc_next_sel #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_sel     (pc_sel),
      .taken      (taken),
      .stall      (stall),
      .rs1        (rs1),
      .imm        (imm),
      .pc         (pc),
      .next_pc    (next_pc),
      .redirect   (redirect),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic [1:0] sel, input logic tk,
                      input logic [31:0] r1, input logic [31:0] im,
                      input logic [31:0] epc, input logic [31:0] enx,
                      input logic erd, input logic ems);
      vec_t v;
      v.stall = st; v.sel = sel; v.taken = tk; v.rs1 = r1; v.imm = im;
      v.exp_pc = epc; v.exp_next = enx; v.exp_red = erd; v.exp_mis = ems;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; pc_sel = S_NONE; taken = 1'b0; stall = 1'b0;
      rs1 = 32'h0; imm = 32'h0;

      // Expected PC chain: each row's exp_next is the next row's exp_pc.
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0);
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0);
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'h0000_0008, 32'h0000_000C, 1'b0, 1'b0);
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'h0000_000C, 32'h0000_0010, 1'b0, 1'b0);
      add(1'b0, S_JAL,  1'b1, 32'h0, 32'h8,         32'h0000_0010, 32'h0000_0018, 1'b1, 1'b0);
      add(1'b0, S_JAL,  1'b1, 32'h0, 32'hFFFF_FFF0, 32'h0000_0018, 32'h0000_0008, 1'b1, 1'b0);
      add(1'b0, S_JALR, 1'b0, 32'h8, 32'h8,         32'h0000_0008, 32'h0000_0010, 1'b1, 1'b0);
      add(1'b0, S_JAL,  1'b0, 32'h0, 32'h8,         32'h0000_0010, 32'h0000_0014, 1'b0, 1'b0);
      add(1'b0, S_JALR, 1'b1, 32'h9, 32'h0,         32'h0000_0014, 32'h0000_0008, 1'b1, 1'b0);
      add(1'b0, S_JALR, 1'b0, 32'h2, 32'h0,         32'h0000_0008, 32'h0000_0002, 1'b1, 1'b1);
      add(1'b0, S_JALR, 1'b0, 32'h10, 32'h0,        32'h0000_0002, 32'h0000_0010, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         add(1'b1, S_ADD4, 1'b0, 32'h0, 32'h0,      32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0);
      add(1'b1, S_JALR, 1'b1, 32'h40, 32'h6,        32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0);
      add(1'b0, S_NONE, 1'b1, 32'h40, 32'h6,        32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0);
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'h0000_0010, 32'h0000_0014, 1'b0, 1'b0);
      add(1'b0, S_JALR, 1'b0, 32'hFFFF_FFF0, 32'hC, 32'h0000_0014, 32'hFFFF_FFFC, 1'b1, 1'b0);
      add(1'b0, S_ADD4, 1'b0, 32'h0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0);
      add(1'b0, S_JAL,  1'b1, 32'h0, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b1);
      add(1'b0, S_JAL,  1'b1, 32'h0, 32'h6,         32'hFFFF_FFFE, 32'h0000_0004, 1'b1, 1'b0);
      add(1'b1, S_JAL,  1'b1, 32'h0, 32'h2,         32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0);
      add(1'b0, S_NONE, 1'b0, 32'h0, 32'h0,         32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0);

      // Reset asserted mid-cycle takes effect without a clock edge.
      #3 rst_n = 1'b0;
      #1 chk("reset_async_pc", pc, 32'h0);
      chk("reset_next_hold", next_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("reset_hold_pc_%0d", c), pc, 32'h0);
      end

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         stall = vecs[i].stall; pc_sel = vecs[i].sel; taken = vecs[i].taken;
         rs1 = vecs[i].rs1; imm = vecs[i].imm;
         @(negedge clk);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("v%0d_next_pc", i), next_pc, vecs[i].exp_next);
         chk($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, vecs[i].exp_red});
         chk($sformatf("v%0d_misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
      end
      @(posedge clk);
      #1 chk("final_vec_pc", pc, 32'h0000_0004);

      // Mid-operation reset while advancing, then first edge after release starts from RESET_PC.
      stall = 1'b0; pc_sel = S_ADD4; taken = 1'b0;
      @(posedge clk);
      #1 chk("pre_reset_pc", pc, 32'h0000_0008);
      #2 rst_n = 1'b0;
      #1 chk("midop_reset_pc", pc, 32'h0);
      chk("midop_reset_next", next_pc, 32'h0000_0004);
      @(posedge clk);
      #1 chk("reset_over_edge_pc", pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("first_edge_pc", pc, 32'h0000_0004);
      @(posedge clk);
      #1 chk("second_edge_pc", pc, 32'h0000_0008);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
